// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder
//   Assembles a framed serial byte stream [SYNC][CMD][PAYLOAD x N, LSB first][CHK]
//   into a command byte plus a 64-bit word, and offers it with a valid/ready
//   handshake. Frames with a bad checksum, and frames that stall between bytes,
//   are discarded and counted.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   rx_data_i      received byte
//   rx_new_i       one-cycle strobe, rx_data_i valid
//   cmd_o          command byte of the last accepted frame
//   word_o         payload of the last accepted frame (byte k -> bits [8k+7:8k])
//   frame_valid_o  frame available, held until frame_ready_i
//   frame_ready_i  consumer accept
//   err_cnt_o      saturating count of checksum failures and timeouts
//   overrun_o      sticky flag: byte dropped while a frame was pending
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// CMD     | next byte is the command
// PAYLOAD | collecting payload bytes into the shadow word
// CHECK   | next byte is the checksum
// HOLD    | frame presented on outputs, waiting for frame_ready_i

module rx_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         PAYLOAD_BYTES  = 8,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_new_i,
  output logic [7:0]  cmd_o,
  output logic [63:0] word_o,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic [7:0]  err_cnt_o,
  output logic        overrun_o
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     LAST_IDX = 3'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t        state_q;
  logic [7:0]    cmd_q;
  logic [63:0]   word_q;
  logic          valid_q;
  logic [7:0]    err_q;
  logic          ovr_q;
  logic [7:0]    cmd_sh_q;
  logic [63:0]   word_sh_q;
  logic [2:0]    idx_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] tmr_q;

  logic [7:0]    err_d;
  logic          in_frame;
  logic          tmr_tc;
  logic          is_sync;

  // Saturating increment: the counter sticks at 255.
  always_comb begin
    err_d = err_q;
    if (err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  assign in_frame = (state_q == CMD) || (state_q == PAYLOAD) || (state_q == CHECK);
  // Expiry only counts when no byte arrives in the same cycle; a byte always wins.
  assign tmr_tc   = in_frame && !rx_new_i && (tmr_q == '0);
  assign is_sync  = rx_new_i && (rx_data_i == SYNC_BYTE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cmd_q     <= 8'd0;
      word_q    <= 64'd0;
      valid_q   <= 1'b0;
      err_q     <= 8'd0;
      ovr_q     <= 1'b0;
      cmd_sh_q  <= 8'd0;
      word_sh_q <= 64'd0;
      idx_q     <= 3'd0;
      chk_q     <= 8'd0;
      tmr_q     <= '0;
    end else begin
      // Inter-byte timer: reloaded on every byte (which includes the SYNC that
      // enters CMD), counts down only while a frame is being collected.
      if (rx_new_i) begin
        tmr_q <= TMR_LOAD;
      end else if (in_frame && (tmr_q != '0)) begin
        tmr_q <= tmr_q - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (is_sync) begin
            word_sh_q <= 64'd0;
            state_q   <= CMD;
          end
        end

        CMD: begin
          if (rx_new_i) begin
            cmd_sh_q <= rx_data_i;
            chk_q    <= rx_data_i;
            idx_q    <= 3'd0;
            state_q  <= PAYLOAD;
          end else if (tmr_tc) begin
            err_q   <= err_d;
            state_q <= IDLE;
          end
        end

        PAYLOAD: begin
          if (rx_new_i) begin
            word_sh_q[{idx_q, 3'b000} +: 8] <= rx_data_i;
            chk_q <= chk_q ^ rx_data_i;
            idx_q <= idx_q + 3'd1;
            if (idx_q == LAST_IDX) state_q <= CHECK;
          end else if (tmr_tc) begin
            err_q   <= err_d;
            state_q <= IDLE;
          end
        end

        CHECK: begin
          if (rx_new_i) begin
            if (rx_data_i == chk_q) begin
              cmd_q   <= cmd_sh_q;
              word_q  <= word_sh_q;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              err_q   <= err_d;
              state_q <= IDLE;
            end
          end else if (tmr_tc) begin
            err_q   <= err_d;
            state_q <= IDLE;
          end
        end

        HOLD: begin
          if (frame_ready_i) begin
            valid_q <= 1'b0;
            // A byte arriving with the accept is treated as if already in IDLE.
            if (is_sync) begin
              word_sh_q <= 64'd0;
              state_q   <= CMD;
            end else begin
              state_q <= IDLE;
            end
          end else if (rx_new_i) begin
            ovr_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_o         = cmd_q;
  assign word_o        = word_q;
  assign frame_valid_o = valid_q;
  assign err_cnt_o     = err_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Bench for rx_frame_decoder: directed frames plus randomized traffic, with every
// cycle's outputs compared against a queue-based reference of the framing rules.
module tb_rx_frame_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         PB   = 8;
  localparam int         TO   = 300;

  logic        clk_sys = 1'b0;
  logic        rst_b;
  logic [7:0]  rx_data;
  logic        rx_new;
  logic [7:0]  cmd;
  logic [63:0] word;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  err_cnt;
  logic        overrun;

  rx_frame_decoder #(
    .SYNC_BYTE      (SYNC),
    .PAYLOAD_BYTES  (PB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk_sys),
    .rst_n_i       (rst_b),
    .rx_data_i     (rx_data),
    .rx_new_i      (rx_new),
    .cmd_o         (cmd),
    .word_o        (word),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .err_cnt_o     (err_cnt),
    .overrun_o     (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bytes collected after SYNC; it is
  // judged once CMD + PB payload + CHK have arrived.
  logic [7:0]  m_cmd;
  logic [63:0] m_word;
  bit          m_valid;
  int          m_err;
  bit          m_ovr;
  bit          m_coll;
  int          m_idle;
  logic [7:0]  m_q[$];

  function automatic void m_reset();
    m_cmd = 8'd0; m_word = 64'd0; m_valid = 0; m_err = 0; m_ovr = 0;
    m_coll = 0; m_idle = 0; m_q.delete();
  endfunction

  function automatic void m_bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_start();
    m_coll = 1; m_idle = 0; m_q.delete();
  endfunction

  function automatic void m_step(input bit rn, input logic [7:0] b, input bit rdy);
    logic [7:0] x;
    if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        if (rn && b == SYNC) m_start();
      end else if (rn) begin
        m_ovr = 1;
      end
    end else if (!m_coll) begin
      if (rn && b == SYNC) m_start();
    end else if (rn) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == PB + 2) begin
        x = 8'd0;
        for (int i = 0; i <= PB; i++) x ^= m_q[i];
        if (x == m_q[PB+1]) begin
          m_cmd  = m_q[0];
          m_word = 64'd0;
          for (int k = 0; k < PB; k++) m_word[8*k +: 8] = m_q[k+1];
          m_valid = 1;
        end else begin
          m_bump_err();
        end
        m_coll = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_coll = 0;
        m_bump_err();
      end
    end
  endfunction

  task automatic check_all();
    chk_eq("valid",   frame_valid, m_valid);
    chk_eq("cmd",     cmd,         m_cmd);
    chk_eq("word",    word,        m_word);
    chk_eq("err_cnt", err_cnt,     m_err[7:0]);
    chk_eq("overrun", overrun,     m_ovr);
  endtask

  int rdy_mode = 0;  // 0: ready low, 1: ready high, 2: random

  function automatic bit rdy_val();
    if (rdy_mode == 2) return ($urandom_range(0, 3) == 0);
    return (rdy_mode == 1);
  endfunction

  task automatic tick(input bit rn, input logic [7:0] b, input bit rdy);
    rx_new = rn; rx_data = b; frame_ready = rdy;
    @(posedge clk_sys);
    m_step(rn, b, rdy);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) tick(1'b0, 8'($urandom), rdy_val());
    tick(1'b1, b, rdy_val());
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [63:0] pl, input bit bad,
                            input int gapmax);
    logic [7:0] x;
    x = c;
    send(SYNC, $urandom_range(0, gapmax));
    send(c, $urandom_range(0, gapmax));
    for (int k = 0; k < PB; k++) begin
      send(pl[8*k +: 8], $urandom_range(0, gapmax));
      x ^= pl[8*k +: 8];
    end
    if (bad) x ^= 8'($urandom_range(1, 255));
    send(x, $urandom_range(0, gapmax));
  endtask

  logic [63:0] rnd_pl;

  initial begin
    rst_b = 1'b0; rx_new = 1'b0; rx_data = 8'd0; frame_ready = 1'b0;
    m_reset();
    #12;
    check_all();
    chk_eq("rst_err", err_cnt, 8'd0);
    rst_b = 1'b1;

    // Reference frame: checksum 01
    rdy_mode = 0;
    send_frame(8'h01, 64'h0123456789ABCDEF, 1'b0, 0);
    chk_eq("t1_valid", frame_valid, 1'b1);
    chk_eq("t1_cmd",   cmd,         8'h01);
    chk_eq("t1_word",  word,        64'h0123456789ABCDEF);
    chk_eq("t1_err",   err_cnt,     8'd0);
    tick(1'b0, 8'h00, 1'b1);
    chk_eq("t1_accept", frame_valid, 1'b0);

    // Same frame with CHK=00
    send(SYNC, 0); send(8'h01, 0);
    for (int k = 0; k < PB; k++) send(8'(64'h0123456789ABCDEF >> (8*k)), 0);
    send(8'h00, 0);
    chk_eq("t2_valid", frame_valid, 1'b0);
    chk_eq("t2_err",   err_cnt,     8'd1);
    chk_eq("t2_word",  word,        64'h0123456789ABCDEF);

    // Stall mid-frame: exactly TO idle cycles
    send(SYNC, 0); send(8'h01, 0); send(8'hEF, 0);
    for (int i = 0; i < TO; i++) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t3_err", err_cnt, 8'd2);
    send_frame(8'h33, 64'h1122334455667788, 1'b0, 2);
    chk_eq("t3_word", word, 64'h1122334455667788);
    tick(1'b0, 8'h00, 1'b1);

    // A byte arriving on the last permissible cycle is taken, not timed out
    send(SYNC, 0); send(8'h44, TO - 1);
    for (int k = 0; k < PB; k++) send(8'(k), (k == 3) ? TO - 1 : 0);
    send(8'h44 ^ 8'h00 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07, TO - 1);
    chk_eq("t3b_valid", frame_valid, 1'b1);
    chk_eq("t3b_err",   err_cnt,     8'd2);

    // Overrun while pending, then accept concurrent with a new SYNC
    send(8'h11, 0); send(8'h22, 1); send(8'h33, 0);
    chk_eq("t4_ovr",  overrun, 1'b1);
    chk_eq("t4_word", word,    64'h0706050403020100);
    tick(1'b1, SYNC, 1'b1);
    chk_eq("t4_drop", frame_valid, 1'b0);
    send(8'h02, 0);
    for (int k = 0; k < PB; k++) send(8'(8'hF0 + k), 0);
    send(8'h02 ^ 8'h00, 0);  // the eight F0..F7 bytes XOR to 00
    chk_eq("t4_new_valid", frame_valid, 1'b1);
    chk_eq("t4_new_word",  word,        64'hF7F6F5F4F3F2F1F0);
    tick(1'b0, 8'h00, 1'b1);

    // Leading junk, SYNC value inside payload
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    send_frame(8'hA5, 64'h00A5A5000000A5A5, 1'b0, 1);
    chk_eq("t5_cmd",  cmd,  8'hA5);
    chk_eq("t5_word", word, 64'h00A5A5000000A5A5);
    tick(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      rnd_pl = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) send(8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        send(SYNC, 0); send(8'($urandom), 0);
        for (int i = 0; i < TO + $urandom_range(0, 3) - 2; i++) tick(1'b0, 8'($urandom), rdy_val());
      end
      send_frame(8'($urandom), rnd_pl, ($urandom_range(0, 3) == 0), 3);
      for (int i = 0; i < $urandom_range(0, 4); i++) tick(1'b0, 8'($urandom), rdy_val());
    end

    // Saturation
    rdy_mode = 1;
    for (int f = 0; f < 256; f++) send_frame(8'($urandom), {$urandom, $urandom}, 1'b1, 0);
    chk_eq("t6_sat", err_cnt, 8'd255);

    // Asynchronous reset mid-payload
    rdy_mode = 0;
    send(SYNC, 0); send(8'h09, 0); send(8'h10, 0); send(8'h20, 0);
    #2 rst_b = 1'b0;
    #1;
    m_reset();
    chk_eq("t6_rst_valid", frame_valid, 1'b0);
    chk_eq("t6_rst_word",  word,        64'd0);
    chk_eq("t6_rst_err",   err_cnt,     8'd0);
    chk_eq("t6_rst_ovr",   overrun,     1'b0);
    chk_eq("t6_rst_cmd",   cmd,         8'd0);
    rst_b = 1'b1;
    send_frame(8'h5C, 64'hDEADBEEFCAFEF00D, 1'b0, 1);
    chk_eq("t6_post_word", word, 64'hDEADBEEFCAFEF00D);
    chk_eq("t6_post_cmd",  cmd,  8'h5C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
